// File: rtl/mul_seq_unit.sv
// -----------------------------------------------------------------------------
// mul_seq_unit
// Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier for the execute
// stage. A start pulse accepted while ready is high latches the operands.
// The unit then retires one multiplier bit per clock for exactly WIDTH
// clocks, with no early exit on zero operands. After that it presents the
// 2*WIDTH-bit product as registered hi/lo halves, together with a one-cycle
// done strobe. lo feeds the b input of the writeback 2:1 mux. The
// controller selects it over the ALU result while done is high.
//
// Ports:
//   clk    in   1      system clock, rising edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request pulse, honoured only while ready=1
//   a      in   WIDTH  multiplicand, sampled on the accepting edge
//   b      in   WIDTH  multiplier, sampled on the accepting edge
//   ready  out  1      high in IDLE and DONE
//   busy   out  1      high in RUN
//   done   out  1      high for the single DONE cycle
//   lo     out  WIDTH  product[WIDTH-1:0], changes only on completion
//   hi     out  WIDTH  product[2*WIDTH-1:WIDTH], changes only on completion
// -----------------------------------------------------------------------------
module mul_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     mcand_r;
    // The low half starts out holding the multiplier. It is consumed from
    // bit 0 while the growing partial product shifts in from the top.
    // The extra top bit keeps the carry out of each add.
    logic [2*WIDTH:0]     acc_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     acc_next_s;

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift right by one.
    always_comb begin
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        acc_next_s = {1'b0, acc_r[2*WIDTH:1]};
        if (acc_r[0]) begin
            acc_next_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
        end else begin
            acc_next_s = {1'b0, acc_r[2*WIDTH:1]};
        end
    end

    // Control FSM, datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            mcand_r <= '0;
            acc_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r <= a;
                        acc_r   <= {{(WIDTH + 1){1'b0}}, b};
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        // The final step's result goes straight to the
                        // outputs, so they never show a partial sum.
                        hi_r    <= acc_next_s[2*WIDTH-1:WIDTH];
                        lo_r    <= acc_next_s[WIDTH-1:0];
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Back-to-back accept. hi/lo keep the old product.
                        mcand_r <= a;
                        acc_r   <= {{(WIDTH + 1){1'b0}}, b};
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule
